imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Extracts and sign/zero-extends every RV immediate format (I, S, B, U, J, shift-amount, CSR zimm) to XLEN bits.
- Output is registered, with one cycle latency and a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure; a side-band tag is carried alongside the result.

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_format.sv | 51 +++++
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// format-select encodings and the XLEN legality check.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_RSVD  = 3'b111;

    // Only RV32 and RV64 result widths are supported.
    localparam int XLEN_LEGAL_A = 32;
    localparam int XLEN_LEGAL_B = 64;

    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == XLEN_LEGAL_A) || (xlen == XLEN_LEGAL_B);
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction and extension for all RV formats.
// Everything is built at 64 bits and then trimmed to XLEN, which keeps
// the concatenations free of zero-width replications when XLEN=32.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic        s;
    logic [63:0] imm_wide;
    logic        unused_bits;

    assign s = instr[31];

    // Select and extend the immediate field; reserved code yields zero plus err.
    always_comb begin
        imm_wide = '0;
        err      = 1'b0;
        case (immsrc)
            IMM_I:     imm_wide = {{52{s}}, instr[31:20]};
            IMM_S:     imm_wide = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B:     imm_wide = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm_wide = {{32{s}}, instr[31:12], 12'b0};
            IMM_J:     imm_wide = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: begin
                if (XLEN == 32) begin
                    imm_wide = {59'b0, instr[24:20]};
                end else begin
                    imm_wide = {58'b0, instr[25:20]};
                end
            end
            IMM_ZIMM:  imm_wide = {59'b0, instr[19:15]};
            default: begin
                imm_wide = '0;
                err      = 1'b1;
            end
        endcase
    end

    assign imm = imm_wide[XLEN-1:0];

    // Opcode bits and the trimmed upper half are intentionally ignored.
    assign unused_bits = ^{instr[6:0], imm_wide};

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational extraction followed by a
// main/skid register pair so the producer never sees a combinational
// dependency on out_ready while still sustaining one word per cycle.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic             imm_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit XLEN_OK = xlen_is_legal(XLEN);

    generate
        if (!XLEN_OK) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("imm_gen_pipe: TAG_W must be at least 1");
        end
    endgenerate

    logic [XLEN-1:0]  fmt_imm;
    logic             fmt_err;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_data_q,  main_data_d;
    logic             main_err_q,   main_err_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_data_q,  skid_data_d;
    logic             skid_err_q,   skid_err_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic             accept;
    logic             drain;

    imm_format #(
        .XLEN (XLEN)
    ) u_format (
        .instr  (instr),
        .immsrc (immsrc),
        .imm    (fmt_imm),
        .err    (fmt_err)
    );

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    // Decide where a new word lands and when skid refills main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        skid_tag_d   = skid_tag_q;

        if (drain && skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_err_d   = skid_err_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_valid_d = 1'b1;
            main_data_d  = fmt_imm;
            main_err_d   = fmt_err;
            main_tag_d   = in_tag;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = fmt_imm;
            skid_err_d   = fmt_err;
            skid_tag_d   = in_tag;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    // Buffer registers; reset empties both entries and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = main_valid_q;
    assign imm_data  = main_data_q;
    assign imm_err   = main_err_q;
    assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; a 2-deep FIFO model plus an arithmetic immediate model
// predict every output.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, imm_err32;
    logic [31:0] imm_data32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] imm_data64;
    logic [4:0]  out_tag64;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [4:0]  tag;
    } word_t;

    word_t model_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_data(imm_data32), .imm_err(imm_err32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_data(imm_data64), .imm_err(imm_err64), .out_tag(out_tag64)
    );

    // Arithmetic reference for the immediate: returns {err, value}.
    function automatic logic [64:0] refImm(input logic [31:0] ins, input logic [2:0] src, input bit x64);
        longint v;
        logic    e;
        e = 1'b0;
        v = 0;
        case (src)
            3'd0: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 8192;
            end
            3'd3: begin
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v = v - 64'sh1_0000_0000;
            end
            3'd4: begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v = v - 2097152;
            end
            3'd5: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: begin
                v = 0;
                e = 1'b1;
            end
        endcase
        if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
        return {e, 64'(v)};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare both instances against the FIFO model at mid-cycle.
    task automatic checkOutput();
        logic [64:0] r32;
        logic [64:0] r64;
        chk("out_valid32", {63'b0, out_valid32}, {63'b0, model_q.size() > 0});
        chk("in_ready32",  {63'b0, in_ready32},  {63'b0, model_q.size() < 2});
        chk("out_valid64", {63'b0, out_valid64}, {63'b0, model_q.size() > 0});
        chk("in_ready64",  {63'b0, in_ready64},  {63'b0, model_q.size() < 2});
        if (model_q.size() > 0) begin
            r32 = refImm(model_q[0].ins, model_q[0].src, 1'b0);
            r64 = refImm(model_q[0].ins, model_q[0].src, 1'b1);
            chk("imm_data32", {32'b0, imm_data32}, r32[63:0]);
            chk("imm_err32",  {63'b0, imm_err32},  {63'b0, r32[64]});
            chk("out_tag32",  {59'b0, out_tag32},  {59'b0, model_q[0].tag});
            chk("imm_data64", imm_data64,          r64[63:0]);
            chk("imm_err64",  {63'b0, imm_err64},  {63'b0, r64[64]});
            chk("out_tag64",  {59'b0, out_tag64},  {59'b0, model_q[0].tag});
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] src,
                                 input logic [4:0] tag, input logic rdy);
        bit acc;
        bit pop;
        in_valid  = v;
        instr     = ins;
        immsrc    = src;
        in_tag    = tag;
        out_ready = rdy;
        @(negedge clk);
        checkOutput();
        acc = v && (model_q.size() < 2);
        pop = rdy && (model_q.size() > 0);
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back('{ins, src, tag});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        immsrc    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        $display("[TB] reset state");
        chk("rst_valid32", {63'b0, out_valid32}, 64'd0);
        chk("rst_ready32", {63'b0, in_ready32},  64'd1);
        chk("rst_data32",  {32'b0, imm_data32},  64'd0);
        chk("rst_err32",   {63'b0, imm_err32},   64'd0);
        chk("rst_tag32",   {59'b0, out_tag32},   64'd0);
        chk("rst_data64",  imm_data64,           64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] back-to-back formats");
        applyStimulus(1'b1, 32'hFFF00093, IMM_I,    5'd0, 1'b1);
        applyStimulus(1'b1, 32'hFE20AE23, IMM_S,    5'd1, 1'b1);
        applyStimulus(1'b1, 32'h00000863, IMM_B,    5'd2, 1'b1);
        applyStimulus(1'b1, 32'h123452B7, IMM_U,    5'd3, 1'b1);
        applyStimulus(1'b1, 32'hFF9FF06F, IMM_J,    5'd4, 1'b1);
        applyStimulus(1'b1, 32'h000F8073, IMM_ZIMM, 5'd5, 1'b1);
        applyStimulus(1'b1, 32'h03F00013, IMM_SHAMT, 5'd6, 1'b1);
        applyStimulus(1'b1, 32'hDEADBEEF, IMM_RSVD, 5'd7, 1'b1);
        applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);
        applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h80000013, IMM_I, 5'd1, 1'b0);
        applyStimulus(1'b1, 32'h7FF00013, IMM_I, 5'd2, 1'b0);
        applyStimulus(1'b1, 32'hFFFFF0B7, IMM_U, 5'd3, 1'b0);
        applyStimulus(1'b1, 32'hFFFFF0B7, IMM_U, 5'd3, 1'b0);
        applyStimulus(1'b1, 32'hFFFFF0B7, IMM_U, 5'd3, 1'b1);
        applyStimulus(1'b1, 32'hFFFFF0B7, IMM_U, 5'd3, 1'b1);
        applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);
        applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);

        $display("[TB] async reset with both entries full");
        applyStimulus(1'b1, 32'h12345013, IMM_I, 5'd9,  1'b0);
        applyStimulus(1'b1, 32'h87654013, IMM_I, 5'd10, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("arst_valid32", {63'b0, out_valid32}, 64'd0);
        chk("arst_ready32", {63'b0, in_ready32},  64'd1);
        chk("arst_valid64", {63'b0, out_valid64}, 64'd0);
        chk("arst_ready64", {63'b0, in_ready64},  64'd1);
        model_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, IMM_I, 5'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
